// File: rtl/seq_subtractor_64.sv
// Multi-cycle subtractor: diff = a - b - b_in, one SLICE-bit slice per clock, LSB first.
// Optional signed-overflow output ovf is built only when SEQ_SUB_OVF_EN is defined.
module seq_subtractor_64 #(
   parameter int WIDTH = 64,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             b_out,
   output logic             zero
`ifdef SEQ_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             borrow_q, borrow_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             b_out_q, b_out_d;
   logic             zero_q, zero_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d;

   logic [SLICE-1:0] a_sl;
   logic [SLICE-1:0] b_sl;
   logic [SLICE:0]   sum;
   logic             last;

   // Slice k = cnt_q; a borrow-in of 1 is a carry-in of 0 in the a + ~b + 1 form.
   always_comb begin
      a_sl = a_q[int'(cnt_q)*SLICE +: SLICE];
      b_sl = b_q[int'(cnt_q)*SLICE +: SLICE];
      sum  = {1'b0, a_sl} + {1'b0, ~b_sl} + {{SLICE{1'b0}}, ~borrow_q};
      last = (cnt_q == CW'(NSLICE - 1));
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      b_out_d  = b_out_q;
      zero_d   = zero_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      ovf_d    = ovf_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               a_d      = a;
               b_d      = b;
               borrow_d = b_in;
               cnt_d    = '0;
               state_d  = S_RUN;
               busy_d   = 1'b1;
            end else begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         end
         S_RUN: begin
            diff_d[int'(cnt_q)*SLICE +: SLICE] = sum[SLICE-1:0];
            borrow_d = ~sum[SLICE];
            if (last) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               b_out_d = ~sum[SLICE];
               zero_d  = (diff_d == '0);
               ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         b_out_q  <= 1'b0;
         zero_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         a_q      <= a_d;
         b_q      <= b_d;
         diff_q   <= diff_d;
         b_out_q  <= b_out_d;
         zero_q   <= zero_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign diff  = diff_q;
   assign b_out = b_out_q;
   assign zero  = zero_q;
`ifdef SEQ_SUB_OVF_EN
   assign ovf   = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_seq_subtractor_64.sv
// Self-checking bench for seq_subtractor_64: directed vector table plus handshake/reset sequences.
module tb_seq_subtractor_64;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [63:0] a;
   logic [63:0] b;
   logic        b_in;
   logic        busy;
   logic        done;
   logic [63:0] diff;
   logic        b_out;
   logic        zero;
`ifdef SEQ_SUB_OVF_EN
   logic        ovf;
`endif

   int checks;
   int failures;

   seq_subtractor_64 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .b_in  (b_in),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .b_out (b_out),
      .zero  (zero)
`ifdef SEQ_SUB_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] va;
      logic [63:0] vb;
      logic        vbin;
      logic [63:0] ediff;
      logic        ebout;
      logic        ezero;
      logic        eovf;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Starts an op, scrambles inputs after acceptance, returns edges until done and busy cycles seen.
   task automatic do_op(input logic [63:0] ta, input logic [63:0] tb, input logic tbin,
                        output int lat, output int busy_cnt);
      @(negedge clk);
      a = ta; b = tb; b_in = tbin; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; a = ~ta; b = ~tb; b_in = ~tbin;
      lat = 0; busy_cnt = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cnt++;
         @(posedge clk);
         #1;
         lat++;
      end
      if (lat >= 20) begin
         failures++;
         checks++;
         $display("FAIL done_timeout actual=no_done expected=done");
      end
   endtask

   vec_t vecs[10];
   int   lat;
   int   bcnt;
   int   seen_done;
   logic [63:0] held;

   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;

      vecs[0] = '{64'd100, 64'd1, 1'b0, 64'd99, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{64'd5, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1};
      vecs[8] = '{64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
      vecs[9] = '{64'd10, 64'd3, 1'b1, 64'd6, 1'b0, 1'b0, 1'b0};

      #12;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_diff", diff, 64'd0);
      chk("rst_bout", {63'd0, b_out}, 64'd0);
      chk("rst_zero", {63'd0, zero}, 64'd0);
`ifdef SEQ_SUB_OVF_EN
      chk("rst_ovf", {63'd0, ovf}, 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         do_op(vecs[i].va, vecs[i].vb, vecs[i].vbin, lat, bcnt);
         chk($sformatf("v%0d_done_edge", i), 64'(lat), 64'd8);
         chk($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'd8);
         chk($sformatf("v%0d_busy_in_done", i), {63'd0, busy}, 64'd0);
         chk($sformatf("v%0d_diff", i), diff, vecs[i].ediff);
         chk($sformatf("v%0d_bout", i), {63'd0, b_out}, {63'd0, vecs[i].ebout});
         chk($sformatf("v%0d_zero", i), {63'd0, zero}, {63'd0, vecs[i].ezero});
`ifdef SEQ_SUB_OVF_EN
         chk($sformatf("v%0d_ovf", i), {63'd0, ovf}, {63'd0, vecs[i].eovf});
`endif
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
         chk($sformatf("v%0d_diff_hold", i), diff, vecs[i].ediff);
      end

      // start pulsed while busy must be ignored
      @(negedge clk);
      a = 64'd100; b = 64'd1; b_in = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      a = 64'd7; b = 64'd2; b_in = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = 4;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("busy_start_done_edge", 64'(lat), 64'd8);
      chk("busy_start_diff", diff, 64'd99);
      @(posedge clk);
      #1;
      chk("busy_start_no_restart", {63'd0, busy}, 64'd0);

      // back-to-back: start held during the DONE cycle
      do_op(64'd20, 64'd5, 1'b0, lat, bcnt);
      chk("b2b_first_done", {63'd0, done}, 64'd1);
      chk("b2b_first_diff", diff, 64'd15);
      a = 64'd50; b = 64'd8; b_in = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; a = '0; b = '0; b_in = 1'b0;
      chk("b2b_busy_again", {63'd0, busy}, 64'd1);
      chk("b2b_done_low", {63'd0, done}, 64'd0);
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("b2b_second_done_edge", 64'(lat), 64'd8);
      chk("b2b_second_diff", diff, 64'd41);

      // reset four cycles into an operation
      do_op(64'd1000, 64'd1, 1'b0, lat, bcnt);
      chk("pre_rst_diff", diff, 64'd999);
      @(negedge clk);
      a = 64'd100; b = 64'd1; b_in = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", {63'd0, busy}, 64'd0);
      chk("mid_rst_diff", diff, 64'd0);
      chk("mid_rst_bout_zero", {62'd0, b_out, zero}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done) seen_done++;
      end
      chk("mid_rst_no_done", 64'(seen_done), 64'd0);
      do_op(64'd40, 64'd2, 1'b0, lat, bcnt);
      chk("post_rst_done_edge", 64'(lat), 64'd8);
      chk("post_rst_diff", diff, 64'd38);
      held = diff;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_hold_diff", diff, 64'd38);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
